// File: rtl/mtr_drv_nch_if.sv
// Bundle between the balance/steering controller (master) and the N-channel
// H-bridge driver (slave): signed speeds, over-current flags and shutdown
// clears in; bridge drives, shutdown status and period strobe out.
interface mtr_drv_nch_if #(
  parameter int NCH   = 2,
  parameter int SPD_W = 12
);
  logic [NCH*SPD_W-1:0] spd;
  logic [NCH-1:0]       ovr_i;
  logic [NCH-1:0]       clr_shtdwn;
  logic [NCH-1:0]       pwm1;
  logic [NCH-1:0]       pwm2;
  logic [NCH-1:0]       ovr_shtdwn;
  logic                 any_shtdwn;
  logic                 pwm_synch;

  modport master (
    output spd, ovr_i, clr_shtdwn,
    input  pwm1, pwm2, ovr_shtdwn, any_shtdwn, pwm_synch
  );

  modport slave (
    input  spd, ovr_i, clr_shtdwn,
    output pwm1, pwm2, ovr_shtdwn, any_shtdwn, pwm_synch
  );
endinterface

// File: rtl/mtr_drv_nch.sv
// N-channel H-bridge motor driver: shared PWM timebase, per-channel signed
// speed to duty conversion latched at period end, dead-time on both
// complementary outputs, over-current blanking, event counting with slow
// decay and latched shutdown with software clear.
// Optional build macro MTR_DRV_COAST_ON_ZERO_EN: a period latched at exactly
// zero speed drives both outputs low (coast) instead of a 50% stiff hold.
module mtr_drv_nch #(
  parameter int NCH       = 2,
  parameter int SPD_W     = 12,
  parameter int PWM_W     = 11,
  parameter int DEAD      = 8,
  parameter int BLANK     = 32,
  parameter int OVR_TRIP  = 31,
  parameter int DECAY_PER = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mtr_drv_nch_if.slave bus
);

  localparam int CW = $clog2(OVR_TRIP + 1);
  localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int PW = (DECAY_PER > 1) ? $clog2(DECAY_PER) : 1;

  localparam logic [PWM_W-1:0] CNT_LAST   = '1;
  localparam logic [PWM_W-1:0] DUTY_MID   = PWM_W'(1) << (PWM_W - 1);
  localparam logic [SPD_W-1:0] SPD_OFS    = SPD_W'(1) << (SPD_W - 1);
  localparam logic [PWM_W:0]   DEAD_X     = (PWM_W + 1)'(DEAD);
  localparam logic [BW-1:0]    BLANK_LD   = BW'(BLANK);
  localparam logic [CW-1:0]    TRIP_CNT   = CW'(OVR_TRIP);
  localparam logic [PW-1:0]    DECAY_LAST = PW'(DECAY_PER - 1);

  // Offset-binary conversion: full negative -> 0, zero -> midscale, full positive -> all-ones.
  function automatic logic [PWM_W-1:0] spd_to_duty(input logic signed [SPD_W-1:0] spd);
    logic [SPD_W-1:0] biased;
    biased = $unsigned(spd) + SPD_OFS;
    return biased[SPD_W-1 -: PWM_W];
  endfunction

  // Event count increment that sticks at the trip value.
  function automatic logic [CW-1:0] evt_inc_sat(input logic [CW-1:0] c);
    return (c >= TRIP_CNT) ? TRIP_CNT : c + 1'b1;
  endfunction

  logic [PWM_W-1:0]            cnt_q, cnt_d;
  logic                        pwm_synch_q, pwm_synch_d;
  logic [PW-1:0]               per_q, per_d;
  logic                        decay_tick;
  logic [PWM_W:0]              cnt_x;

  logic [NCH-1:0][PWM_W-1:0]   duty_q, duty_d;
  logic [NCH-1:0]              a_prev_q, a_prev_d;
  logic [NCH-1:0]              b_prev_q, b_prev_d;
  logic [NCH-1:0][BW-1:0]      blank_q, blank_d;
  logic [NCH-1:0]              ovr_ff1_q, ovr_ff1_d;
  logic [NCH-1:0]              ovr_ff2_q, ovr_ff2_d;
  logic [NCH-1:0]              ovr_ff3_q, ovr_ff3_d;
  logic [NCH-1:0]              inhibit_q, inhibit_d;
  logic [NCH-1:0][CW-1:0]      evt_cnt_q, evt_cnt_d;
  logic [NCH-1:0]              ovr_shtdwn_q, ovr_shtdwn_d;
  logic [NCH-1:0]              pwm1_q, pwm1_d;
  logic [NCH-1:0]              pwm2_q, pwm2_d;
`ifdef MTR_DRV_COAST_ON_ZERO_EN
  logic [NCH-1:0]              coast_q, coast_d;
`endif

  logic [NCH-1:0]              a_raw, b_raw, blank, rise, gate;

  assign cnt_x = {1'b0, cnt_q};

  // Shared timebase: free-running counter, end-of-period strobe, decay period count
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    pwm_synch_d = (cnt_d == CNT_LAST);
    per_d       = per_q;
    decay_tick  = 1'b0;
    if (pwm_synch_q) begin
      per_d      = (per_q == DECAY_LAST) ? '0 : per_q + 1'b1;
      decay_tick = (per_q == DECAY_LAST);
    end
  end

  // Per-channel compare, blanking, over-current qualification and shutdown
  always_comb begin
    a_raw        = '0;
    b_raw        = '0;
    blank        = '0;
    rise         = '0;
    gate         = '0;
    duty_d       = duty_q;
    a_prev_d     = a_prev_q;
    b_prev_d     = b_prev_q;
    blank_d      = blank_q;
    ovr_ff1_d    = ovr_ff1_q;
    ovr_ff2_d    = ovr_ff2_q;
    ovr_ff3_d    = ovr_ff3_q;
    inhibit_d    = inhibit_q;
    evt_cnt_d    = evt_cnt_q;
    ovr_shtdwn_d = ovr_shtdwn_q;
    pwm1_d       = '0;
    pwm2_d       = '0;
`ifdef MTR_DRV_COAST_ON_ZERO_EN
    coast_d      = coast_q;
`endif
    for (int i = 0; i < NCH; i++) begin
      // Extra MSB keeps duty+DEAD from wrapping, so B simply never rises near full scale.
      a_raw[i] = (cnt_x >= DEAD_X) && (cnt_x < {1'b0, duty_q[i]});
      b_raw[i] = (cnt_x >= ({1'b0, duty_q[i]} + DEAD_X));
      blank[i] = (blank_q[i] != '0);
      rise[i]  = ovr_ff2_q[i] & ~ovr_ff3_q[i];
      gate[i]  = ovr_ff2_q[i] | inhibit_q[i] | ovr_shtdwn_q[i];

      if (pwm_synch_q) begin
        duty_d[i] = spd_to_duty(bus.spd[i*SPD_W +: SPD_W]);
      end

      // Switching transients on either leg trip the comparator; mask them for BLANK clk.
      a_prev_d[i] = a_raw[i];
      b_prev_d[i] = b_raw[i];
      if ((a_raw[i] & ~a_prev_q[i]) | (b_raw[i] & ~b_prev_q[i])) begin
        blank_d[i] = BLANK_LD;
      end else if (blank[i]) begin
        blank_d[i] = blank_q[i] - 1'b1;
      end

      ovr_ff1_d[i] = bus.ovr_i[i] & ~blank[i];
      ovr_ff2_d[i] = ovr_ff1_q[i];
      ovr_ff3_d[i] = ovr_ff2_q[i];

      // Period end releases the inhibit even if a new event lands in the same cycle.
      if (pwm_synch_q) begin
        inhibit_d[i] = 1'b0;
      end else if (rise[i]) begin
        inhibit_d[i] = 1'b1;
      end

      if (bus.clr_shtdwn[i]) begin
        evt_cnt_d[i] = '0;
      end else if (rise[i] && !inhibit_q[i]) begin
        evt_cnt_d[i] = evt_inc_sat(evt_cnt_q[i]);
      end else if (decay_tick && (evt_cnt_q[i] != '0)) begin
        evt_cnt_d[i] = evt_cnt_q[i] - 1'b1;
      end

      if (bus.clr_shtdwn[i]) begin
        ovr_shtdwn_d[i] = 1'b0;
      end else if (evt_cnt_q[i] == TRIP_CNT) begin
        ovr_shtdwn_d[i] = 1'b1;
      end

      pwm1_d[i] = a_raw[i] & ~gate[i];
      pwm2_d[i] = b_raw[i] & ~gate[i];

`ifdef MTR_DRV_COAST_ON_ZERO_EN
      if (pwm_synch_q) begin
        coast_d[i] = (bus.spd[i*SPD_W +: SPD_W] == '0);
      end
      if (coast_q[i]) begin
        pwm1_d[i] = 1'b0;
        pwm2_d[i] = 1'b0;
      end
`endif
    end
  end

  // State registers; asynchronous reset drops every bridge drive immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      pwm_synch_q  <= 1'b0;
      per_q        <= '0;
      duty_q       <= {NCH{DUTY_MID}};
      a_prev_q     <= '0;
      b_prev_q     <= '0;
      blank_q      <= '0;
      ovr_ff1_q    <= '0;
      ovr_ff2_q    <= '0;
      ovr_ff3_q    <= '0;
      inhibit_q    <= '0;
      evt_cnt_q    <= '0;
      ovr_shtdwn_q <= '0;
      pwm1_q       <= '0;
      pwm2_q       <= '0;
`ifdef MTR_DRV_COAST_ON_ZERO_EN
      coast_q      <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      pwm_synch_q  <= pwm_synch_d;
      per_q        <= per_d;
      duty_q       <= duty_d;
      a_prev_q     <= a_prev_d;
      b_prev_q     <= b_prev_d;
      blank_q      <= blank_d;
      ovr_ff1_q    <= ovr_ff1_d;
      ovr_ff2_q    <= ovr_ff2_d;
      ovr_ff3_q    <= ovr_ff3_d;
      inhibit_q    <= inhibit_d;
      evt_cnt_q    <= evt_cnt_d;
      ovr_shtdwn_q <= ovr_shtdwn_d;
      pwm1_q       <= pwm1_d;
      pwm2_q       <= pwm2_d;
`ifdef MTR_DRV_COAST_ON_ZERO_EN
      coast_q      <= coast_d;
`endif
    end
  end

  assign bus.pwm1       = pwm1_q;
  assign bus.pwm2       = pwm2_q;
  assign bus.ovr_shtdwn = ovr_shtdwn_q;
  assign bus.any_shtdwn = |ovr_shtdwn_q;
  assign bus.pwm_synch  = pwm_synch_q;

endmodule

// File: tb/tb_mtr_drv_nch.sv
// Bench for mtr_drv_nch with a reduced configuration (short PWM period) so
// shutdown and decay sequences fit in a short run. A time-indexed behavioural
// model predicts every output cycle by cycle; directed checks pin the pulse
// widths and over-current scenarios to values derived by hand.
module tb_mtr_drv_nch;
  localparam int NCH       = 3;
  localparam int SPD_W     = 8;
  localparam int PWM_W     = 6;
  localparam int DEAD      = 3;
  localparam int BLANK     = 6;
  localparam int OVR_TRIP  = 5;
  localparam int DECAY_PER = 4;
  localparam int P         = 1 << PWM_W;
  localparam int SPD_MAX   = (1 << (SPD_W - 1)) - 1;
  localparam int SPD_MIN   = -(1 << (SPD_W - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  mtr_drv_nch_if #(.NCH(NCH), .SPD_W(SPD_W)) bus ();

  mtr_drv_nch #(
    .NCH(NCH), .SPD_W(SPD_W), .PWM_W(PWM_W), .DEAD(DEAD),
    .BLANK(BLANK), .OVR_TRIP(OVR_TRIP), .DECAY_PER(DECAY_PER)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_cnt, m_per, m_edge;
  int   m_duty [NCH];
  int   m_load [NCH];
  int   m_evt  [NCH];
  bit   m_pa [NCH], m_pb [NCH], m_inh [NCH], m_sd [NCH], m_coast [NCH];
  bit   m_hist [NCH][3];
  logic [NCH-1:0] m_pwm1, m_pwm2;
  logic m_synch;

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_edge = 0; m_synch = 1'b0;
    m_pwm1 = '0; m_pwm2 = '0;
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = P / 2; m_load[i] = -1000; m_evt[i] = 0;
      m_pa[i] = 0; m_pb[i] = 0; m_inh[i] = 0; m_sd[i] = 0; m_coast[i] = 0;
      for (int k = 0; k < 3; k++) m_hist[i][k] = 0;
    end
  endtask

  task automatic model_step();
    bit synch_now, decay, a, b, blank, rise, gate;
    logic signed [SPD_W-1:0] s;
    int sv;
    m_edge++;
    synch_now = (m_cnt == P - 1);
    decay     = synch_now && (m_per == DECAY_PER - 1);
    for (int i = 0; i < NCH; i++) begin
      a     = (m_cnt >= DEAD) && (m_cnt < m_duty[i]);
      b     = (m_cnt >= m_duty[i] + DEAD);
      blank = (m_edge - m_load[i]) <= BLANK;
      rise  = m_hist[i][1] && !m_hist[i][2];
      gate  = m_hist[i][1] || m_inh[i] || m_sd[i];
      m_pwm1[i] = a && !gate;
      m_pwm2[i] = b && !gate;
`ifdef MTR_DRV_COAST_ON_ZERO_EN
      if (m_coast[i]) begin m_pwm1[i] = 1'b0; m_pwm2[i] = 1'b0; end
`endif
      if ((a && !m_pa[i]) || (b && !m_pb[i])) m_load[i] = m_edge;
      m_pa[i] = a; m_pb[i] = b;
      m_hist[i][2] = m_hist[i][1];
      m_hist[i][1] = m_hist[i][0];
      m_hist[i][0] = bus.ovr_i[i] && !blank;
      if (bus.clr_shtdwn[i]) m_sd[i] = 0;
      else if (m_evt[i] == OVR_TRIP) m_sd[i] = 1;
      if (bus.clr_shtdwn[i]) m_evt[i] = 0;
      else if (rise && !m_inh[i]) m_evt[i] = (m_evt[i] + 1 > OVR_TRIP) ? OVR_TRIP : m_evt[i] + 1;
      else if (decay && m_evt[i] > 0) m_evt[i] = m_evt[i] - 1;
      m_inh[i] = synch_now ? 1'b0 : (rise ? 1'b1 : m_inh[i]);
      if (synch_now) begin
        s  = bus.spd[i*SPD_W +: SPD_W];
        sv = int'(s);
        m_duty[i]  = ((sv + (1 << (SPD_W - 1))) % (1 << SPD_W)) / (1 << (SPD_W - PWM_W));
        m_coast[i] = (sv == 0);
      end
    end
    if (synch_now) m_per = (m_per + 1) % DECAY_PER;
    m_cnt   = (m_cnt + 1) % P;
    m_synch = (m_cnt == P - 1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("pwm1", bus.pwm1, m_pwm1);
    chk("pwm2", bus.pwm2, m_pwm2);
    chk("pwm_synch", bus.pwm_synch, m_synch);
    chk("ovr_shtdwn", bus.ovr_shtdwn, {m_sd[2], m_sd[1], m_sd[0]});
    chk("any_shtdwn", bus.any_shtdwn, m_sd[0] | m_sd[1] | m_sd[2]);
    chk("exclusive", |(bus.pwm1 & bus.pwm2), 1'b0);
    for (int i = 0; i < NCH; i++) chk("evt_cnt", dut.evt_cnt_q[i], m_evt[i]);
  end

  // ---------------- stimulus ----------------
  task automatic set_spd(input int ch, input int val);
    bus.spd[ch*SPD_W +: SPD_W] = SPD_W'(val);
  endtask

  function automatic int rand_spd();
    case ($urandom_range(4))
      0:       return SPD_MIN;
      1:       return SPD_MAX;
      2:       return 0;
      default: return int'($urandom_range((1 << SPD_W) - 1)) + SPD_MIN;
    endcase
  endfunction

  task automatic width_check(input int ch, input int want_a, input int want_b);
    int na, nb;
    na = 0; nb = 0;
    repeat (P) begin
      @(negedge clk);
      na += int'(bus.pwm1[ch]);
      nb += int'(bus.pwm2[ch]);
    end
    chk("width_a", na, want_a);
    chk("width_b", nb, want_b);
  endtask

  task automatic pulse_ovr(input int ch, input int at_cnt);
    int g;
    g = 0;
    while (m_cnt != at_cnt && g < 2 * P) begin
      @(negedge clk);
      g++;
    end
    bus.ovr_i[ch] = 1'b1;
    @(negedge clk);
    bus.ovr_i[ch] = 1'b0;
  endtask

  task automatic rand_cycles(input int n, input int ovr_pct, input int clr_pm, input int spd_pct);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(99) < spd_pct) set_spd(i, rand_spd());
        bus.ovr_i[i]      = ($urandom_range(99) < ovr_pct);
        bus.clr_shtdwn[i] = ($urandom_range(999) < clr_pm);
      end
    end
    @(negedge clk);
    bus.ovr_i = '0;
    bus.clr_shtdwn = '0;
  endtask

  initial begin
    bus.spd = '0; bus.ovr_i = '0; bus.clr_shtdwn = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm1", bus.pwm1, '0);
    chk("rst_pwm2", bus.pwm2, '0);
    chk("rst_synch", bus.pwm_synch, 1'b0);
    chk("rst_any", bus.any_shtdwn, 1'b0);
    rst_n = 1'b1;

    // Zero speed: 50% complementary with dead-time
    repeat (2 * P) @(negedge clk);
    width_check(0, P / 2 - DEAD, P - (P / 2 + DEAD));
    width_check(2, P / 2 - DEAD, P - (P / 2 + DEAD));

    // Extremes, changed mid-period
    repeat (P / 3) @(negedge clk);
    set_spd(0, SPD_MAX); set_spd(1, SPD_MIN); set_spd(2, 4);
    repeat (2 * P) @(negedge clk);
    width_check(0, P - 1 - DEAD, 0);
    width_check(1, 0, P - DEAD);
    width_check(2, 33 - DEAD, P - (33 + DEAD));

    // Over-current on channel 0: blanked pulse, counted pulse, second pulse in same period, decay
    set_spd(0, 0); set_spd(1, 0); set_spd(2, 0);
    repeat (2 * P) @(negedge clk);
    pulse_ovr(0, DEAD + 2);
    repeat (3) @(negedge clk);
    chk("blanked_pwm1", bus.pwm1[0], 1'b1);
    chk("blanked_cnt", dut.evt_cnt_q[0], 0);
    pulse_ovr(0, 20);
    repeat (4) @(negedge clk);
    chk("ovr_gate", bus.pwm1[0] | bus.pwm2[0], 1'b0);
    chk("ovr_cnt", dut.evt_cnt_q[0], 1);
    chk("ch1_indep", bus.pwm1[1], 1'b1);
    chk("ch1_cnt", dut.evt_cnt_q[1], 0);
    pulse_ovr(0, 50);
    repeat (4) @(negedge clk);
    chk("second_evt", dut.evt_cnt_q[0], 1);
    repeat ((DECAY_PER + 1) * P) @(negedge clk);
    chk("decayed", dut.evt_cnt_q[0], 0);

    // Repeated events on channel 1 until shutdown, then software clear
    for (int k = 0; k < 2 * OVR_TRIP; k++) pulse_ovr(1, 20);
    repeat (4) @(negedge clk);
    chk("trip_sd", bus.ovr_shtdwn[1], 1'b1);
    chk("trip_any", bus.any_shtdwn, 1'b1);
    repeat (P / 2) @(negedge clk);
    chk("trip_off", bus.pwm1[1] | bus.pwm2[1], 1'b0);
    bus.clr_shtdwn[1] = 1'b1;
    @(negedge clk);
    bus.clr_shtdwn[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_sd", bus.ovr_shtdwn[1], 1'b0);
    chk("clr_cnt", dut.evt_cnt_q[1], 0);
    repeat (2 * P) @(negedge clk);

    // Random traffic
    rand_cycles(60 * P, 2, 4, 3);
    repeat (4 * P) @(negedge clk);

    // Asynchronous reset in the middle of a period
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm1", bus.pwm1, '0);
    chk("arst_pwm2", bus.pwm2, '0);
    chk("arst_sd", bus.ovr_shtdwn, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_cycles(20 * P, 2, 4, 3);
    repeat (P) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
